timer_dec_down: RTL and testbench
=================================

# timer_dec_down

MM:SS countdown timer that runs the opposite way from the team's decimal up-counters. It is loaded with a BCD minute/second value and decrements once per one-cycle `clk_sec` strobe from the shared clock-divider chain. At 00:00 it stops and raises `alarm`. Its four BCD digits feed the FND display driver directly, and `alarm` drives a buzzer or LED.

## Interface
Parameters:
- `ALARM_SEC`, default 10: seconds `alarm` stays high before auto-clear. Used only when `TIMER_AUTO_CLEAR_EN` is defined.

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `reset_p`  in  1: asynchronous, active-high reset.
- `clk_sec`  in  1: one-`clk`-wide strobe, once per second.
- `btn_start`  in  1: one-cycle pulse that toggles run/pause.
- `btn_load`  in  1: one-cycle pulse that loads the `set_*` values.
- `set_min10`, `set_min1`, `set_sec10`, `set_sec1`  in  4 each: BCD preset.
- `min10`, `min1`, `sec10`, `sec1`  out  4 each: current BCD time, registered.
- `running`  out  1: high while in RUN.
- `alarm`  out  1: high while in ALARM.

## Operation
- States:
  - IDLE: stopped, value held.
  - RUN: counting down.
  - PAUSE: frozen mid-count.
  - ALARM: reached zero.
- Reset: all digits 0, `running`=0, `alarm`=0, state IDLE.
- Load:
  - `btn_load` in any state copies the presets into the digits and goes to IDLE.
  - In ALARM it also clears `alarm`.
  - Presets saturate: `set_sec1`, `set_min1`, `set_min10` > 9 load 9; `set_sec10` > 5 loads 5.
- Start/pause:
  - IDLE + `btn_start` goes to RUN, unless the value is 00:00. In that case it stays IDLE.
  - RUN + `btn_start` goes to PAUSE.
  - PAUSE + `btn_start` goes to RUN.
  - ALARM + `btn_start` clears `alarm` and goes to IDLE with the digits at 00:00.
- Priority when inputs coincide in one cycle:
  - `btn_load` overrides `btn_start`.
  - `btn_start` overrides a `clk_sec` decrement. The value is held that cycle and the tick is lost.
- Decrement, only in RUN on a `clk_sec` strobe, as a borrow chain:
  - `sec1` > 0: `sec1`−1. Otherwise `sec1`=9 and borrow into `sec10`.
  - `sec10` > 0: `sec10`−1. Otherwise `sec10`=5 and borrow into `min1`.
  - `min1` > 0: `min1`−1. Otherwise `min1`=9 and borrow into `min10`.
  - `min10` decrements; it never underflows because 00:00 is trapped first.
- Zero detect: if the decrement produces 00:00, the state goes to ALARM on the same edge. `running` drops and `alarm` rises.
- In ALARM, `clk_sec` has no effect on the digits.
- Digits never leave the BCD ranges: `sec10` 0–5, all other digits 0–9.

## Timing
- All outputs are registered and change only on a `clk` rising edge, except on `reset_p`.
- A decrement is visible 1 `clk` after the edge that samples `clk_sec`=1.
- 00:01 → 00:00 and `alarm`=1 appear on the same edge.
- Start to first decrement is 1 to 100,000,000 `clk` cycles. The `clk_sec` phase is free-running and is not realigned on start.
- Load and button effects are visible 1 `clk` after the pulse.
- `reset_p` asserted mid-count returns to the reset values immediately (asynchronous). The count is not resumed after reset.

## Configuration
- `TIMER_AUTO_CLEAR_EN` defined:
  - In ALARM, an internal counter counts `clk_sec` strobes.
  - After `ALARM_SEC` strobes, `alarm` clears and the state goes to IDLE.
  - The counter zeroes on entry to ALARM.
- `TIMER_AUTO_CLEAR_EN` undefined:
  - ALARM holds until `btn_start`, `btn_load` or reset.
  - `ALARM_SEC` is unused.

## Structure
- Package `timer_pkg` holds:
  - the state encoding (IDLE, RUN, PAUSE, ALARM);
  - the constants `BCD_MAX_UNIT`=9 and `BCD_MAX_TENS_SEC`=5.
- Sub-module `bcd_digit_down`, instantiated four times:
  - one BCD digit with parameter MAX;
  - inputs `dec_en` and `load`/`load_val`;
  - output `borrow_out`, asserted when the digit is 0 and `dec_en` is high, at which point the digit wraps to MAX.
- The top level chains the digit borrows, holds the FSM, and does zero detect.

## Test plan
- Load 00:03, start, 3 strobes → digits 00:02, 00:01, 00:00. `alarm`=1 and `running`=0 on the third strobe edge.
- Load 10:00, start, 1 strobe → 09:59 (borrow across all digits).
- Load 00:05, start, 2 strobes, `btn_start`, 3 strobes → holds 00:03. `btn_start` again, 3 strobes → 00:00 with `alarm`.
- Load 00:00 then `btn_start` → stays IDLE, `running`=0. Load with `set_sec10`=7, `set_sec1`=12 → loads 00:59.
- `btn_load` and `btn_start` in the same cycle → preset loaded, IDLE. `clk_sec` and `btn_start` in the same cycle in RUN → PAUSE, value unchanged.
- Alarm exit and reset:
  - With `TIMER_AUTO_CLEAR_EN` and `ALARM_SEC`=2: `alarm` clears after 2 strobes.
  - Without the macro: `alarm` persists for 5 strobes, then clears on `btn_start`.
  - `reset_p` mid-RUN → all outputs 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: FSM state encoding,
// BCD digit limits and preset saturation helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_UNIT     = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

  function automatic logic [3:0] sat_bcd(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One down-counting BCD digit; wraps to MAX and raises borrow_out when
// decremented from zero.
module bcd_digit_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       dec_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       borrow_out
);

  assign borrow_out = dec_en && (value == 4'd0);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec_en) begin
      value <= (value == 4'd0) ? MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/timer_dec_down.sv
// MM:SS BCD countdown timer with run/pause/alarm FSM.
// Optional macro TIMER_AUTO_CLEAR_EN: alarm self-clears after ALARM_SEC strobes.
module timer_dec_down
  import timer_pkg::*;
#(
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_load,
  input  logic [3:0] set_min10,
  input  logic [3:0] set_min1,
  input  logic [3:0] set_sec10,
  input  logic [3:0] set_sec1,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm
);

  state_t state;
  logic   tick;
  logic   load_en;
  logic   is_zero;
  logic   is_one;
  logic   borrow_s1;
  logic   borrow_s10;
  logic   borrow_m1;
  logic [3:0] ld_m10, ld_m1, ld_s10, ld_s1;

  // Buttons pre-empt the strobe: a tick coinciding with either is dropped.
  assign tick    = clk_sec && (state == RUN) && !btn_load && !btn_start;
  assign load_en = btn_load || ((state == ALARM) && btn_start);

  assign is_zero = (min10 == 4'd0) && (min1 == 4'd0) && (sec10 == 4'd0) && (sec1 == 4'd0);
  assign is_one  = (min10 == 4'd0) && (min1 == 4'd0) && (sec10 == 4'd0) && (sec1 == 4'd1);

  always_comb begin
    ld_m10 = '0;
    ld_m1  = '0;
    ld_s10 = '0;
    ld_s1  = '0;
    if (btn_load) begin
      ld_m10 = sat_bcd(set_min10, BCD_MAX_UNIT);
      ld_m1  = sat_bcd(set_min1,  BCD_MAX_UNIT);
      ld_s10 = sat_bcd(set_sec10, BCD_MAX_TENS_SEC);
      ld_s1  = sat_bcd(set_sec1,  BCD_MAX_UNIT);
    end
  end

  bcd_digit_down #(.MAX(BCD_MAX_UNIT)) u_sec1 (
    .clk(clk), .reset_p(reset_p), .dec_en(tick), .load(load_en),
    .load_val(ld_s1), .value(sec1), .borrow_out(borrow_s1)
  );

  bcd_digit_down #(.MAX(BCD_MAX_TENS_SEC)) u_sec10 (
    .clk(clk), .reset_p(reset_p), .dec_en(borrow_s1), .load(load_en),
    .load_val(ld_s10), .value(sec10), .borrow_out(borrow_s10)
  );

  bcd_digit_down #(.MAX(BCD_MAX_UNIT)) u_min1 (
    .clk(clk), .reset_p(reset_p), .dec_en(borrow_s10), .load(load_en),
    .load_val(ld_m1), .value(min1), .borrow_out(borrow_m1)
  );

  // 00:00 is trapped before min10 could borrow, so its borrow is never used.
  bcd_digit_down #(.MAX(BCD_MAX_UNIT)) u_min10 (
    .clk(clk), .reset_p(reset_p), .dec_en(borrow_m1), .load(load_en),
    .load_val(ld_m10), .value(min10), .borrow_out()
  );

`ifdef TIMER_AUTO_CLEAR_EN
  logic [31:0] alarm_cnt;
`endif

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= IDLE;
      running <= 1'b0;
      alarm   <= 1'b0;
`ifdef TIMER_AUTO_CLEAR_EN
      alarm_cnt <= '0;
`endif
    end else if (btn_load) begin
      state   <= IDLE;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else if (btn_start) begin
      unique case (state)
        IDLE: begin
          if (!is_zero) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          state   <= PAUSE;
          running <= 1'b0;
        end
        PAUSE: begin
          state   <= RUN;
          running <= 1'b1;
        end
        ALARM: begin
          state <= IDLE;
          alarm <= 1'b0;
        end
      endcase
    end else if (clk_sec) begin
      if (state == RUN && is_one) begin
        state   <= ALARM;
        running <= 1'b0;
        alarm   <= 1'b1;
`ifdef TIMER_AUTO_CLEAR_EN
        alarm_cnt <= '0;
`endif
      end
`ifdef TIMER_AUTO_CLEAR_EN
      else if (state == ALARM) begin
        if (alarm_cnt + 32'd1 >= 32'(ALARM_SEC)) begin
          state <= IDLE;
          alarm <= 1'b0;
        end
        alarm_cnt <= alarm_cnt + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_timer_dec_down.sv
// Directed + randomized bench for timer_dec_down against a seconds-count model.
module tb_timer_dec_down;

  localparam int unsigned ALARM_SEC_TB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_p, clk_sec, btn_start, btn_load;
  logic [3:0] set_min10, set_min1, set_sec10, set_sec1;
  logic [3:0] min10, min1, sec10, sec1;
  logic       running, alarm;

  timer_dec_down #(.ALARM_SEC(ALARM_SEC_TB)) dut (
    .clk(clk), .reset_p(reset_p), .clk_sec(clk_sec),
    .btn_start(btn_start), .btn_load(btn_load),
    .set_min10(set_min10), .set_min1(set_min1),
    .set_sec10(set_sec10), .set_sec1(set_sec1),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .running(running), .alarm(alarm)
  );

  int checks = 0;
  int fails  = 0;

  // Model: total remaining seconds plus a mode (0 idle, 1 run, 2 pause, 3 alarm).
  int secs = 0;
  int mode = 0;
  int acnt = 0;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_step(input logic ld, input logic st, input logic tk);
    if (ld) begin
      secs = sat(int'(set_min10), 9) * 600 + sat(int'(set_min1), 9) * 60 +
             sat(int'(set_sec10), 5) * 10 + sat(int'(set_sec1), 9);
      mode = 0;
    end else if (st) begin
      case (mode)
        0: if (secs != 0) mode = 1;
        1: mode = 2;
        2: mode = 1;
        default: begin mode = 0; secs = 0; end
      endcase
    end else if (tk) begin
      if (mode == 1) begin
        secs = secs - 1;
        if (secs == 0) begin mode = 3; acnt = 0; end
      end
`ifdef TIMER_AUTO_CLEAR_EN
      else if (mode == 3) begin
        acnt = acnt + 1;
        if (acnt >= int'(ALARM_SEC_TB)) mode = 0;
      end
`endif
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_d;
    exp_d = {4'(secs / 600), 4'((secs / 60) % 10), 4'((secs % 60) / 10), 4'(secs % 10)};
    check({tag, ".digits"},  {min10, min1, sec10, sec1}, exp_d);
    check({tag, ".running"}, {15'd0, running}, {15'd0, mode == 1});
    check({tag, ".alarm"},   {15'd0, alarm},   {15'd0, mode == 3});
  endtask

  task automatic preset(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    set_min10 = a; set_min1 = b; set_sec10 = c; set_sec1 = d;
  endtask

  task automatic cyc(input string tag, input logic ld, input logic st, input logic tk);
    btn_load = ld; btn_start = st; clk_sec = tk;
    @(posedge clk);
    model_step(ld, st, tk);
    #1;
    btn_load = 1'b0; btn_start = 1'b0; clk_sec = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset_p = 1'b1; clk_sec = 1'b0; btn_start = 1'b0; btn_load = 1'b0;
    preset(4'd0, 4'd0, 4'd0, 4'd0);
    #12;
    check_all("reset");
    @(negedge clk);
    reset_p = 1'b0;

    // 00:03 counts down to alarm
    preset(4'd0, 4'd0, 4'd0, 4'd3);
    cyc("ld003", 1, 0, 0);
    cyc("st003", 0, 1, 0);
    cyc("gap", 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) cyc("dn003", 0, 0, 1);

    // Borrow across every digit
    preset(4'd1, 4'd0, 4'd0, 4'd0);
    cyc("ld1000", 1, 0, 0);
    cyc("st1000", 0, 1, 0);
    cyc("dn1000", 0, 0, 1);

    // Pause / resume
    preset(4'd0, 4'd0, 4'd0, 4'd5);
    cyc("ld005", 1, 0, 0);
    cyc("st005", 0, 1, 0);
    for (int unsigned i = 0; i < 2; i++) cyc("run005", 0, 0, 1);
    cyc("pause", 0, 1, 0);
    for (int unsigned i = 0; i < 3; i++) cyc("paused", 0, 0, 1);
    cyc("resume", 0, 1, 0);
    for (int unsigned i = 0; i < 3; i++) cyc("run003", 0, 0, 1);

    // Alarm dwell, then exit by start
    for (int unsigned i = 0; i < 5; i++) cyc("alarm_hold", 0, 0, 1);
    cyc("alarm_exit", 0, 1, 0);

    // Zero start refused; saturating presets
    preset(4'd0, 4'd0, 4'd0, 4'd0);
    cyc("ld000", 1, 0, 0);
    cyc("st000", 0, 1, 0);
    preset(4'd0, 4'd0, 4'd7, 4'd12);
    cyc("ld_sat", 1, 0, 0);
    preset(4'd15, 4'd10, 4'd6, 4'd9);
    cyc("ld_sat2", 1, 0, 0);

    // Coincident inputs
    preset(4'd0, 4'd2, 4'd3, 4'd4);
    cyc("st", 0, 1, 0);
    cyc("ld_and_st", 1, 1, 0);
    cyc("st234", 0, 1, 0);
    cyc("tick_and_st", 0, 1, 1);
    cyc("resume234", 0, 1, 0);
    cyc("dn234", 0, 0, 1);

    // Asynchronous reset mid-run
    #2;
    reset_p = 1'b1;
    secs = 0; mode = 0; acnt = 0;
    #1;
    check_all("async_reset");
    @(negedge clk);
    check_all("reset_hold");
    reset_p = 1'b0;

    // Random traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      logic ld, st, tk;
      preset(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
             ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      ld = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 19) == 0);
      tk = ($urandom_range(0, 1) == 0);
      cyc("rand", ld, st, tk);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
